// File: rtl/bitmap_writeback.sv
// bitmap_writeback
//   Packs the 64-bit per-cache-line filter bitmaps of one scanned block into
//   512-bit result lines (8 bitmaps per line), writes each completed line to
//   the host result buffer over CCI-P channel 1, counts write acks and
//   reports block completion. Bitmaps may arrive in any order.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                one-cycle pulse: load wr_base_i/total_cls_i, begin block
//   wr_base_i              cache-line address of the result buffer
//   total_cls_i            source cache lines in the block (1..64)
//   bm_valid_i/bm_cl_idx_i/bm_data_i   incoming bitmap and its source index
//   c1_tx_alm_full_i       channel-1 almost-full
//   wr_rsp_valid_i         one write acknowledgement
//   wr_valid_o/wr_addr_o/wr_mdata_o/wr_data_o   registered write request
//   busy_o, done_o, err_o  block status (err is sticky until start)
//
// state   | meaning
// IDLE    | no block loaded
// COLLECT | accepting bitmaps, issuing completed lines
// DRAIN   | every line issued, waiting for the remaining acks
// DONE    | all lines written and acknowledged
module bitmap_writeback #(
  parameter int ADDR_W  = 42,
  parameter int MDATA_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [ADDR_W-1:0]  wr_base_i,
  input  logic [6:0]         total_cls_i,
  input  logic               bm_valid_i,
  input  logic [5:0]         bm_cl_idx_i,
  input  logic [63:0]        bm_data_i,
  input  logic               c1_tx_alm_full_i,
  input  logic               wr_rsp_valid_i,
  output logic               wr_valid_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [MDATA_W-1:0] wr_mdata_o,
  output logic [511:0]       wr_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [6:0]         total_q, total_d;
  logic [3:0]         ln_q, ln_d;          // lines needed, 1..8
  logic [7:0]         last_mask_q, last_mask_d;
  logic [7:0]         mask_q [8];
  logic [7:0]         mask_d [8];
  logic [511:0]       data_q [8];
  logic [511:0]       data_d [8];
  logic [7:0]         issued_q, issued_d;
  logic [3:0]         ack_q, ack_d;
  logic               err_q, err_d;
  logic               wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [MDATA_W-1:0] wr_mdata_q, wr_mdata_d;
  logic [511:0]       wr_data_q, wr_data_d;

  logic [7:0] ready;
  logic [2:0] sel;
  logic       issue;
  logic [7:0] need_mask;
  logic [2:0] bm_line;
  logic [2:0] bm_lane;

  assign bm_line   = bm_cl_idx_i[5:3];
  assign bm_lane   = bm_cl_idx_i[2:0];
  assign need_mask = 8'((9'd1 << ln_q) - 9'd1);

  // Readiness uses registered masks only, so a bitmap completing a line
  // cannot issue that line in the same cycle.
  always_comb begin
    ready = '0;
    for (int l = 0; l < 8; l++) begin
      if ((4'(l) < ln_q) && !issued_q[l]) begin
        if (4'(l) == ln_q - 4'd1) ready[l] = (mask_q[l] == last_mask_q);
        else                      ready[l] = (mask_q[l] == 8'hFF);
      end
    end
  end

  // Lowest-index ready line wins.
  always_comb begin
    sel = 3'd0;
    for (int l = 7; l >= 0; l--) begin
      if (ready[l]) sel = 3'(l);
    end
  end

  assign issue = (state_q == COLLECT) && (|ready) && !c1_tx_alm_full_i;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    total_d     = total_q;
    ln_d        = ln_q;
    last_mask_d = last_mask_q;
    mask_d      = mask_q;
    data_d      = data_q;
    issued_d    = issued_q;
    ack_d       = ack_q;
    err_d       = err_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_mdata_d  = wr_mdata_q;
    wr_data_d   = wr_data_q;

    if (state_q == IDLE || state_q == DONE) begin
      if (start_i) begin
        state_d     = COLLECT;
        base_d      = wr_base_i;
        total_d     = total_cls_i;
        ln_d        = total_cls_i[6:3] + {3'b000, |total_cls_i[2:0]};
        last_mask_d = (total_cls_i[2:0] == 3'd0) ? 8'hFF
                    : 8'((9'd1 << total_cls_i[2:0]) - 9'd1);
        mask_d      = '{default: '0};
        data_d      = '{default: '0};
        issued_d    = '0;
        ack_d       = '0;
        err_d       = 1'b0;
      end
    end else begin
      if (start_i) err_d = 1'b1;
      if (wr_rsp_valid_i) begin
        if (ack_q == ln_q) err_d = 1'b1;
        else               ack_d = ack_q + 4'd1;
      end
    end

    if (state_q == COLLECT) begin
      if (bm_valid_i) begin
        if ({1'b0, bm_cl_idx_i} >= total_q || issued_q[bm_line]) begin
          err_d = 1'b1;
        end else begin
          if (mask_q[bm_line][bm_lane]) err_d = 1'b1;
          mask_d[bm_line][bm_lane]                = 1'b1;
          data_d[bm_line][{bm_lane, 6'd0} +: 64] = bm_data_i;
        end
      end
      if (issue) begin
        issued_d[sel] = 1'b1;
        wr_valid_d    = 1'b1;
        wr_addr_d     = base_q + ADDR_W'(sel);
        wr_mdata_d    = MDATA_W'(sel);
        wr_data_d     = data_q[sel];
      end
      if ((issued_d & need_mask) == need_mask) state_d = DRAIN;
    end

    if (state_q == DRAIN && ack_q == ln_q) state_d = DONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      base_q      <= '0;
      total_q     <= '0;
      ln_q        <= '0;
      last_mask_q <= '0;
      mask_q      <= '{default: '0};
      data_q      <= '{default: '0};
      issued_q    <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_mdata_q  <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      total_q     <= total_d;
      ln_q        <= ln_d;
      last_mask_q <= last_mask_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      issued_q    <= issued_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_mdata_q  <= wr_mdata_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_mdata_o = wr_mdata_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = (state_q == COLLECT) || (state_q == DRAIN);
  assign done_o     = (state_q == DONE);
  assign err_o      = err_q;

endmodule

// File: tb/tb_bitmap_writeback.sv
// Directed self-checking bench for bitmap_writeback.
module tb_bitmap_writeback;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [41:0]  wr_base;
  logic [6:0]   total;
  logic         bm_valid;
  logic [5:0]   bm_idx;
  logic [63:0]  bm_data;
  logic         alm;
  logic         wr_rsp;
  logic         wr_valid;
  logic [41:0]  wr_addr;
  logic [15:0]  wr_mdata;
  logic [511:0] wr_data;
  logic         busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  // write monitor / auto-ack (acks come back 4 cycles after each write)
  logic         auto_ack;
  logic         man_ack;
  logic [3:0]   ack_pipe = '0;
  int           mon_n = 0;
  int           cyc = 0;
  logic [41:0]  mon_addr  [64];
  logic [15:0]  mon_mdata [64];
  logic [511:0] mon_data  [64];
  int           mon_cyc   [64];

  assign wr_rsp = (auto_ack & ack_pipe[3]) | man_ack;

  always #5 clk = ~clk;

  bitmap_writeback #(.ADDR_W(42), .MDATA_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .wr_base_i(wr_base),
    .total_cls_i(total), .bm_valid_i(bm_valid), .bm_cl_idx_i(bm_idx),
    .bm_data_i(bm_data), .c1_tx_alm_full_i(alm), .wr_rsp_valid_i(wr_rsp),
    .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_mdata_o(wr_mdata),
    .wr_data_o(wr_data), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_valid && rst_n && mon_n < 64) begin
      mon_addr[mon_n]  <= wr_addr;
      mon_mdata[mon_n] <= wr_mdata;
      mon_data[mon_n]  <= wr_data;
      mon_cyc[mon_n]   <= cyc;
      mon_n            <= mon_n + 1;
    end
    if (auto_ack) ack_pipe <= {ack_pipe[2:0], wr_valid & rst_n};
    else          ack_pipe <= '0;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [41:0] base, input logic [6:0] tot);
    start = 1'b1; wr_base = base; total = tot;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int i, input logic [63:0] d);
    bm_valid = 1'b1; bm_idx = 6'(i); bm_data = d;
    tick();
    bm_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k = 0;
    while (!done && k < lim) begin
      tick();
      k++;
    end
    chk(tag, 512'(done), 512'd1);
  endtask

  initial begin
    int m;
    logic [511:0] exp;
    int ord [16] = '{15, 3, 8, 0, 1, 2, 4, 5, 6, 7, 9, 10, 11, 12, 13, 14};

    rst_n = 1'b0; start = 1'b0; wr_base = '0; total = '0; bm_valid = 1'b0;
    bm_idx = '0; bm_data = '0; alm = 1'b0; auto_ack = 1'b1; man_ack = 1'b0;
    #23;
    chk("rst_wr_valid", 512'(wr_valid), 512'd0);
    chk("rst_wr_addr",  512'(wr_addr),  512'd0);
    chk("rst_wr_data",  wr_data,        512'd0);
    chk("rst_status",   512'({busy, done, err}), 512'd0);
    rst_n = 1'b1;
    tick();

    // in-order, full block
    m = mon_n;
    do_start(42'h1000, 7'd64);
    for (int i = 0; i < 64; i++) begin
      feed(i, 64'(i));
      if (i == 7) chk("lat_not_yet", 512'(wr_valid), 512'd0);
      if (i == 8) chk("lat_issue", 512'({wr_valid, wr_mdata}), 512'({1'b1, 16'd0}));
    end
    wait_done("inorder_done", 100);
    chk("inorder_count", 512'(mon_n - m), 512'd8);
    for (int l = 0; l < 8; l++) begin
      for (int j = 0; j < 8; j++) exp[64*j +: 64] = 64'(8*l + j);
      chk("inorder_addr",  512'(mon_addr[m+l]),  512'(42'h1000 + 42'(l)));
      chk("inorder_mdata", 512'(mon_mdata[m+l]), 512'(l));
      chk("inorder_data",  mon_data[m+l], exp);
    end
    chk("inorder_status", 512'({busy, err}), 512'd0);

    // out-of-order, 16 lines of all-ones
    m = mon_n;
    do_start(42'h2000, 7'd16);
    for (int i = 0; i < 16; i++) feed(ord[i], {64{1'b1}});
    wait_done("ooo_done", 50);
    chk("ooo_count", 512'(mon_n - m), 512'd2);
    chk("ooo_mdata_set", 512'(mon_mdata[m] + mon_mdata[m+1]), 512'd1);
    for (int l = 0; l < 2; l++) begin
      chk("ooo_addr", 512'(mon_addr[m+l]), 512'(42'h2000 + 42'(mon_mdata[m+l])));
      chk("ooo_data", mon_data[m+l], {512{1'b1}});
    end

    // partial last line
    m = mon_n;
    do_start(42'h30, 7'd5);
    for (int i = 0; i < 5; i++) feed(i, 64'hA5);
    wait_done("part_done", 50);
    exp = '0;
    for (int j = 0; j < 5; j++) exp[64*j +: 64] = 64'hA5;
    chk("part_count", 512'(mon_n - m), 512'd1);
    chk("part_data", mon_data[m], exp);
    chk("part_addr", 512'(mon_addr[m]), 512'h30);
    chk("part_err", 512'(err), 512'd0);

    // backpressure with 3 ready lines
    m = mon_n;
    alm = 1'b1;
    do_start(42'h4000, 7'd24);
    for (int i = 0; i < 24; i++) feed(i, 64'(i));
    for (int c = 0; c < 20; c++) chk("bp_no_write", 512'(wr_valid), 512'd0);
    chk("bp_no_write_count", 512'(mon_n - m), 512'd0);
    for (int c = 0; c < 20; c++) tick();
    chk("bp_still_none", 512'(mon_n - m), 512'd0);
    alm = 1'b0;
    wait_done("bp_done", 50);
    chk("bp_count", 512'(mon_n - m), 512'd3);
    for (int l = 0; l < 3; l++) chk("bp_order", 512'(mon_mdata[m+l]), 512'(l));
    chk("bp_consec1", 512'(mon_cyc[m+1] - mon_cyc[m]), 512'd1);
    chk("bp_consec2", 512'(mon_cyc[m+2] - mon_cyc[m+1]), 512'd1);

    // protocol errors
    m = mon_n;
    do_start(42'h400, 7'd8);
    feed(10, 64'hBAD);
    chk("err_idx_range", 512'(err), 512'd1);
    feed(0, 64'd0); feed(1, 64'd1); feed(2, 64'h22); feed(2, 64'h99);
    for (int i = 3; i < 7; i++) feed(i, 64'(i));
    do_start(42'h999, 7'd3);
    chk("err_start_busy", 512'({busy, err}), 512'b11);
    feed(7, 64'd7);
    wait_done("err_done", 50);
    exp = '0;
    for (int j = 0; j < 8; j++) exp[64*j +: 64] = 64'(j);
    exp[128 +: 64] = 64'h99;
    chk("err_count", 512'(mon_n - m), 512'd1);
    chk("err_addr", 512'(mon_addr[m]), 512'h400);
    chk("err_dup_data", mon_data[m], exp);
    chk("err_sticky", 512'(err), 512'd1);
    do_start(42'h500, 7'd1);
    chk("err_cleared", 512'({busy, done, err}), 512'b100);
    feed(0, 64'hDEAD);
    wait_done("err_next_done", 50);
    chk("err_next_data", mon_data[mon_n-1], 512'h DEAD);
    chk("err_next_err", 512'(err), 512'd0);

    // reset in DRAIN with acks pending
    m = mon_n;
    auto_ack = 1'b0;
    do_start(42'h5000, 7'd16);
    for (int i = 0; i < 16; i++) feed(i, 64'(i + 1));
    for (int c = 0; c < 3; c++) tick();
    chk("drain_busy", 512'({busy, done}), 512'b10);
    chk("drain_writes", 512'(mon_n - m), 512'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 512'(wr_valid), 512'd0);
    chk("mrst_addr",  512'({wr_addr, wr_mdata}), 512'd0);
    chk("mrst_data",  wr_data, 512'd0);
    chk("mrst_status", 512'({busy, done, err}), 512'd0);
    tick();
    rst_n = 1'b1;
    tick();
    man_ack = 1'b1;
    tick(); tick();
    man_ack = 1'b0;
    tick();
    chk("late_ack_ignored", 512'({busy, done, err}), 512'd0);
    auto_ack = 1'b1;
    m = mon_n;
    do_start(42'h6000, 7'd8);
    for (int i = 0; i < 8; i++) feed(i, 64'hF0 + 64'(i));
    wait_done("post_rst_done", 50);
    chk("post_rst_count", 512'(mon_n - m), 512'd1);
    chk("post_rst_addr", 512'(mon_addr[m]), 512'h6000);
    chk("post_rst_err", 512'(err), 512'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bitmap_writeback.md
# bitmap_writeback

Downstream stage of the per-block scan pipeline. It collects the 64-bit filter bitmaps produced for each scanned cache line, packs eight of them into one 512-bit result line, and writes each completed line to the host result buffer over CCI-P channel 1. It tracks write acknowledgements and reports block completion to the CSR logic. Bitmaps may arrive out of order because read responses return out of order; the block tolerates this.

## Interface
Parameters:
- ADDR_W, 42, cache-line address width (matches t_cci_clAddr)
- MDATA_W, 16, c1 request mdata width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; loads wr_base and total_cls and begins a block
- wr_base  in  ADDR_W  cache-line address of the result buffer for this block
- total_cls  in  7  source cache lines in the block, legal 1..64
- bm_valid  in  1  a bitmap is presented this cycle
- bm_cl_idx  in  6  source cache-line index of the bitmap (read mdata)
- bm_data  in  64  bitmap for that cache line
- c1TxAlmFull  in  1  channel-1 almost-full from the FIU
- wr_rsp_valid  in  1  one write acknowledgement this cycle
- wr_valid  out  1  write request valid; the parent adds vc_sel=eVC_VA, req_type=eREQ_WRLINE_I, sop=1, cl_len=eCL_LEN_1
- wr_addr  out  ADDR_W  wr_base + line index
- wr_mdata  out  MDATA_W  line index, zero-extended
- wr_data  out  512  packed line; lane j occupies bits [64j+63:64j]
- busy  out  1  block in progress
- done  out  1  all lines written and acknowledged; held until the next start
- err  out  1  sticky protocol error; cleared by start

## Operation
- Mapping: line = bm_cl_idx[5:3], lane = bm_cl_idx[2:0]. Storage is 8 lines x 512 bits, with an 8-bit lane mask and an issued flag per line.
- lines_needed = (total_cls + 7) >> 3, range 1..8. The last line's expected mask is (1 << (total_cls - 8*(lines_needed-1))) - 1; every other line expects 8'hFF. Unused lanes of a partial last line are written as zero.
- A line is ready when its mask equals its expected mask and it has not been issued.
- States:
  - IDLE: start -> COLLECT.
  - COLLECT: accept bitmaps and issue ready lines. After the final line is issued -> DRAIN.
  - DRAIN: count acknowledgements. ack_cnt == lines_needed -> DONE.
  - DONE: start -> COLLECT.
- start in IDLE or DONE clears masks, issued flags, ack_cnt, err, and the storage. start in COLLECT or DRAIN is ignored and sets err.
- bm_valid outside COLLECT is ignored.
- bm_cl_idx >= total_cls: bitmap dropped, err set.
- Duplicate lane on a line not yet issued: data overwritten, err set. Any bitmap for an issued line: dropped, err set.
- Issue: at most one write per cycle. The lowest-index ready line is issued when c1TxAlmFull is low in the deciding cycle. That line is marked issued in the same edge that registers wr_valid.
- wr_rsp_valid is counted in COLLECT and DRAIN. Acks above lines_needed set err and are otherwise ignored.
- busy = state is COLLECT or DRAIN. done = state is DONE.

## Timing
- Reset (reset low, asynchronous): state IDLE; wr_valid, wr_addr, wr_mdata, wr_data, busy, done, err all 0; masks and flags cleared. Reset asserted mid-block abandons the block; outstanding acks that arrive after reset releases are ignored in IDLE.
- All outputs are registered. wr_valid is a single-cycle pulse per line; wr_addr, wr_mdata and wr_data are valid only while wr_valid is high.
- Latency: a bitmap completing a line at edge k updates the mask. The issue decision uses registered masks, so wr_valid is high after edge k+1, provided c1TxAlmFull was low in cycle k+1 and no lower-index line was ready.
- c1TxAlmFull high: no new wr_valid. A request already registered still completes.
- bm_valid and an issue in the same cycle: both take effect. A bitmap that completes a line cannot issue that line in the same cycle.
- The last issue and wr_rsp_valid may coincide; the ack is counted. The transition to DONE occurs on the edge after ack_cnt reaches lines_needed.
- busy deasserts and done asserts on the same edge.

## Test plan
- In-order: total_cls=64, wr_base=0x1000, bitmaps idx 0..63 with bm_data=idx, acks returned 4 cycles after each write -> 8 writes, addr 0x1000..0x1007, mdata 0..7; line 0 lane j = j; done high after the 8th ack.
- Out-of-order: total_cls=16, idx order 15,3,8,0,...; every bitmap all-ones -> exactly 2 writes; line 1 may issue before line 0; each wr_data = all-ones.
- Partial last line: total_cls=5, bitmaps 0..4 = 64'hA5 -> one write with lanes 0..4 = A5 and lanes 5..7 = 0; done after 1 ack.
- Backpressure: c1TxAlmFull high for 20 cycles while 3 lines are ready -> no wr_valid during that window; then 3 consecutive writes at lines 0, 1, 2.
- Errors: idx 10 with total_cls=8, a duplicate lane, and start while busy -> err=1, the block still completes; the next start clears err.
- Reset mid-DRAIN with 2 acks pending -> all outputs 0 immediately; late acks ignored; a new start runs normally.
